// File: rtl/watch_time_counter.sv
// 24-hour BCD time-of-day counter (HH:MM:SS). Advances once per clock_en tick and
// accepts per-digit up/down adjustment from edge-detected request levels.
module watch_time_counter (
    input  logic       clk_6mhz,
    input  logic       rst,
    input  logic       clock_en,
    input  logic [5:0] digit,
    input  logic       up,
    input  logic       down,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hrs0,
    output logic [3:0] hrs1
);

    logic up_q, down_q;
    logic up_evt, down_evt, adj;
    logic [3:0] n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1;
    logic [3:0] h0_max;

    // Out-of-range values fall back into range on the next step.
    function automatic logic [3:0] step_up(input logic [3:0] d, input logic [3:0] mx);
        return (d >= mx) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] step_dn(input logic [3:0] d, input logic [3:0] mx);
        return (d == 4'd0 || d > mx) ? mx : d - 4'd1;
    endfunction

    function automatic logic [3:0] step(input logic [3:0] d, input logic [3:0] mx, input logic dir_up);
        return dir_up ? step_up(d, mx) : step_dn(d, mx);
    endfunction

    assign up_evt   = up & ~up_q;
    assign down_evt = down & ~down_q;
    assign adj      = up_evt ^ down_evt;

    always_comb begin
        n_sec0 = sec0;
        n_sec1 = sec1;
        n_min0 = min0;
        n_min1 = min1;
        n_hrs0 = hrs0;
        n_hrs1 = hrs1;
        h0_max = 4'd9;
        if (adj) begin
            // Each masked digit moves alone; hours units range follows the new tens digit.
            if (digit[0]) n_sec0 = step(sec0, 4'd9, up_evt);
            if (digit[1]) n_sec1 = step(sec1, 4'd5, up_evt);
            if (digit[2]) n_min0 = step(min0, 4'd9, up_evt);
            if (digit[3]) n_min1 = step(min1, 4'd5, up_evt);
            if (digit[5]) n_hrs1 = step(hrs1, 4'd2, up_evt);
            h0_max = (n_hrs1 == 4'd2) ? 4'd3 : 4'd9;
            if (digit[4]) n_hrs0 = step(hrs0, h0_max, up_evt);
            if (n_hrs1 == 4'd2 && n_hrs0 > 4'd3) n_hrs0 = 4'd3;
        end else if (clock_en) begin
            n_sec0 = step_up(sec0, 4'd9);
            if (sec0 >= 4'd9) begin
                n_sec1 = step_up(sec1, 4'd5);
                if (sec1 >= 4'd5) begin
                    n_min0 = step_up(min0, 4'd9);
                    if (min0 >= 4'd9) begin
                        n_min1 = step_up(min1, 4'd5);
                        if (min1 >= 4'd5) begin
                            // 23 -> 00 rollover, otherwise ordinary hours carry.
                            if (hrs1 >= 4'd2 && hrs0 >= 4'd3) begin
                                n_hrs0 = 4'd0;
                                n_hrs1 = 4'd0;
                            end else if (hrs0 >= 4'd9) begin
                                n_hrs0 = 4'd0;
                                n_hrs1 = step_up(hrs1, 4'd2);
                            end else begin
                                n_hrs0 = hrs0 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_6mhz or posedge rst) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            sec0   <= 4'd0;
            sec1   <= 4'd0;
            min0   <= 4'd0;
            min1   <= 4'd0;
            hrs0   <= 4'd0;
            hrs1   <= 4'd0;
        end else begin
            up_q   <= up;
            down_q <= down;
            sec0   <= n_sec0;
            sec1   <= n_sec1;
            min0   <= n_min0;
            min1   <= n_min1;
            hrs0   <= n_hrs0;
            hrs1   <= n_hrs1;
        end
    end

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed bench for watch_time_counter; time is compared as a 24-bit BCD word HHMMSS.
module tb_watch_time_counter;

    logic       clk_6mhz = 1'b0;
    logic       rst = 1'b1;
    logic       clock_en = 1'b0;
    logic [5:0] digit = 6'd0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [3:0] sec0, sec1, min0, min1, hrs0, hrs1;
    logic [23:0] t;

    int n_cmp = 0;
    int n_fail = 0;

    watch_time_counter dut (
        .clk_6mhz(clk_6mhz), .rst(rst), .clock_en(clock_en), .digit(digit),
        .up(up), .down(down), .sec0(sec0), .sec1(sec1), .min0(min0),
        .min1(min1), .hrs0(hrs0), .hrs1(hrs1)
    );

    always #5 clk_6mhz = ~clk_6mhz;

    assign t = {hrs1, hrs0, min1, min0, sec1, sec0};

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk_6mhz);
    endtask

    task automatic pulse_up(input logic [5:0] m, input int n);
        digit = m;
        repeat (n) begin
            up = 1'b1; cyc();
            up = 1'b0; cyc();
        end
    endtask

    // Reset, then dial each digit up from zero; hours tens first so units range is final.
    task automatic load_time(input logic [23:0] v);
        @(negedge clk_6mhz);
        rst = 1'b1; up = 1'b0; down = 1'b0; clock_en = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        pulse_up(6'b100000, int'(v[23:20]));
        pulse_up(6'b010000, int'(v[19:16]));
        pulse_up(6'b001000, int'(v[15:12]));
        pulse_up(6'b000100, int'(v[11:8]));
        pulse_up(6'b000010, int'(v[7:4]));
        pulse_up(6'b000001, int'(v[3:0]));
        digit = 6'd0;
        n_cmp++;
        if (t !== v) begin
            n_fail++;
            $display("FAIL load_time got %h want %h", t, v);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; up = 1'b1; down = 1'b1; clock_en = 1'b1; digit = 6'h3f;
        #1;
        n_cmp++;
        if (t !== 24'h000000) begin n_fail++; $display("FAIL reset_async got %h want 000000", t); end
        cyc(3);
        n_cmp++;
        if (t !== 24'h000000) begin n_fail++; $display("FAIL reset_held got %h want 000000", t); end
        up = 1'b0; down = 1'b0; clock_en = 1'b0; digit = 6'd0;
        cyc();
        rst = 1'b0;
        cyc(100);
        n_cmp++;
        if (t !== 24'h000000) begin n_fail++; $display("FAIL reset_idle got %h want 000000", t); end
    endtask

    task automatic test_adjust_up;
        load_time(24'h000000);
        digit = 6'b101010;
        up = 1'b1; cyc(2); up = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h101010) begin n_fail++; $display("FAIL adj_up_first got %h want 101010", t); end
        up = 1'b1; cyc(2); up = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h202020) begin n_fail++; $display("FAIL adj_up_second got %h want 202020", t); end
        digit = 6'b000000;
        up = 1'b1; cyc(); up = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h202020) begin n_fail++; $display("FAIL adj_mask_zero got %h want 202020", t); end
    endtask

    task automatic test_adjust_down_wrap;
        load_time(24'h000000);
        digit = 6'b101010;
        down = 1'b1; cyc(); down = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h205050) begin n_fail++; $display("FAIL adj_down_wrap got %h want 205050", t); end
        load_time(24'h230000);
        pulse_up(6'b010000, 1);
        n_cmp++;
        if (t !== 24'h200000) begin n_fail++; $display("FAIL adj_hrs0_wrap got %h want 200000", t); end
    endtask

    task automatic test_hours_clamp;
        load_time(24'h190000);
        pulse_up(6'b100000, 1);
        n_cmp++;
        if (t !== 24'h230000) begin n_fail++; $display("FAIL hrs_clamp got %h want 230000", t); end
    endtask

    task automatic test_count_carry;
        load_time(24'h235958);
        clock_en = 1'b1; cyc(); clock_en = 1'b0;
        n_cmp++;
        if (t !== 24'h235959) begin n_fail++; $display("FAIL count_tick1 got %h want 235959", t); end
        cyc(2);
        clock_en = 1'b1; cyc(); clock_en = 1'b0;
        n_cmp++;
        if (t !== 24'h000000) begin n_fail++; $display("FAIL count_midnight got %h want 000000", t); end
        load_time(24'h095959);
        clock_en = 1'b1; cyc(); clock_en = 1'b0;
        n_cmp++;
        if (t !== 24'h100000) begin n_fail++; $display("FAIL count_hour_carry got %h want 100000", t); end
    endtask

    task automatic test_conflicts;
        load_time(24'h000000);
        digit = 6'b111111;
        up = 1'b1; down = 1'b1; cyc(); up = 1'b0; down = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h000000) begin n_fail++; $display("FAIL both_edges got %h want 000000", t); end
        up = 1'b1; down = 1'b1; clock_en = 1'b1; cyc();
        up = 1'b0; down = 1'b0; clock_en = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h000001) begin n_fail++; $display("FAIL both_edges_tick got %h want 000001", t); end
        digit = 6'b000001;
        up = 1'b1; clock_en = 1'b1; cyc(); up = 1'b0; clock_en = 1'b0;
        n_cmp++;
        if (t !== 24'h000002) begin n_fail++; $display("FAIL adj_beats_tick got %h want 000002", t); end
        clock_en = 1'b1; cyc(); clock_en = 1'b0;
        n_cmp++;
        if (t !== 24'h000003) begin n_fail++; $display("FAIL tick_after_adj got %h want 000003", t); end
    endtask

    task automatic test_mid_reset;
        load_time(24'h000000);
        clock_en = 1'b1; cyc(5);
        n_cmp++;
        if (t !== 24'h000005) begin n_fail++; $display("FAIL count_run got %h want 000005", t); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (t !== 24'h000000) begin n_fail++; $display("FAIL mid_reset got %h want 000000", t); end
        clock_en = 1'b0;
        cyc();
        rst = 1'b0;
        // First level-high up after release must count as an edge.
        digit = 6'b000001; up = 1'b1; cyc(); up = 1'b0; cyc();
        n_cmp++;
        if (t !== 24'h000001) begin n_fail++; $display("FAIL up_after_reset got %h want 000001", t); end
    endtask

    initial begin
        test_reset();
        test_adjust_up();
        test_adjust_down_wrap();
        test_hours_clamp();
        test_count_carry();
        test_conflicts();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
